reg_file_wr_arb: RTL

- Write-port arbiter for the small register file (DEPTH = 2**ADDR_W entries x DATA_W bits).
- NUM_REQ requesters share the file's single write path.
- Round-robin grant with an optional bounded burst lock.
- Drives registered wr_en/wr_addr/wr_data into the register file's next-value logic; read path untouched.

---
 rtl/reg_file_wr_arb_if.sv | 27 ++
 rtl/reg_file_wr_arb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_file_wr_arb_if.sv
// Write-request bundle between the register-file requesters and the write-port arbiter.
// The master side drives requests, the slave side (arbiter) drives the registered write path.
interface reg_file_wr_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 1,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ-1:0]        lock_in;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic                      wr_en_out;
    logic [ADDR_W-1:0]         wr_addr_out;
    logic [DATA_W-1:0]         wr_data_out;
    logic                      busy_out;

    modport master (
        output req_in, lock_in, addr_in, data_in,
        input  gnt_out, wr_en_out, wr_addr_out, wr_data_out, busy_out
    );

    modport slave (
        input  req_in, lock_in, addr_in, data_in,
        output gnt_out, wr_en_out, wr_addr_out, wr_data_out, busy_out
    );
endinterface

// File: rtl/reg_file_wr_arb.sv
// Round-robin write-port arbiter with bounded burst lock for a small register file.
// Define REG_FILE_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-first priority.
module reg_file_wr_arb #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 1,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    reg_file_wr_arb_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W:0]   HOLD_LIM = (CNT_W + 1)'(MAX_HOLD);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  owner, owner_nxt, win;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W:0]    cnt_inc;
    logic [NUM_REQ-1:0] gnt, gnt_nxt;
    logic              wr_en, wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [DATA_W-1:0] wr_data, wr_data_nxt;
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.addr_in[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = bus.data_in[g*DATA_W +: DATA_W];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [PTR_W-1:0] pick;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i[PTR_W-1:0]]) pick = i[PTR_W-1:0];
        end
        return pick;
    endfunction

`ifndef REG_FILE_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0] ptr, ptr_nxt;

    // Rotate requests so bit k is requester (start+k) mod NUM_REQ, then take the first set bit.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [PTR_W:0]       sum;
        dbl = {req, req} >> start;
        rot = dbl[NUM_REQ-1:0];
        sum = {1'b0, start} + {1'b0, lowest_set(rot)};
        if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
        return sum[PTR_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    endfunction

    assign win = rr_pick(bus.req_in, ptr);
`else
    assign win = lowest_set(bus.req_in);
`endif

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        cnt_inc     = {1'b0, cnt} + (CNT_W + 1)'(1);
        gnt_nxt     = '0;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
`ifndef REG_FILE_ARB_FIXED_PRIO_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            ARB: begin
                if (|bus.req_in) begin
                    gnt_nxt     = onehot(win);
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr_arr[win];
                    wr_data_nxt = data_arr[win];
                    cnt_nxt     = CNT_W'(1);
`ifndef REG_FILE_ARB_FIXED_PRIO_EN
                    ptr_nxt     = wrap_inc(win);
`endif
                    if (bus.lock_in[win] && MAX_HOLD > 1) begin
                        state_nxt = HOLD;
                        owner_nxt = win;
                    end
                end
            end
            HOLD: begin
                // Other requesters wait; a dropped owner request costs one idle cycle.
                if (bus.req_in[owner]) begin
                    gnt_nxt     = onehot(owner);
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr_arr[owner];
                    wr_data_nxt = data_arr[owner];
                    cnt_nxt     = cnt_inc[CNT_W-1:0];
                    if (!bus.lock_in[owner] || cnt_inc == HOLD_LIM) state_nxt = ARB;
                end else begin
                    state_nxt = ARB;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ARB;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
`ifndef REG_FILE_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
`ifndef REG_FILE_ARB_FIXED_PRIO_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

    assign bus.gnt_out     = gnt;
    assign bus.wr_en_out   = wr_en;
    assign bus.wr_addr_out = wr_addr;
    assign bus.wr_data_out = wr_data;
    assign bus.busy_out    = (state == HOLD);
endmodule
